grey_encoder_16: RTL and testbench

GREY_ENCODER_16 -- requirements
Module: grey_encoder_16

---
 rtl/grey_encoder_16.sv | 45 ++++
 tb/tb_grey_encoder_16.sv | 119 +++++++++++
 2 files changed

// File: rtl/grey_encoder_16.sv
// grey_encoder_16: 16-bit binary-to-Gray encoder with internal Gray counter and a one-word output buffer
module grey_encoder_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] b,
    input  logic        count_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] g,
    output logic [15:0] cnt
);
    logic        v_q, v_d;
    logic [15:0] g_q, g_d;
    logic [15:0] cnt_q, cnt_d;
    logic        slot_free, ld_conv, ld_cnt;

    always_comb begin
        slot_free = !v_q || out_ready;
        in_ready  = !rst && !mode && slot_free;
        ld_conv   = in_valid && in_ready;
        ld_cnt    = !rst && mode && count_en && slot_free;
        g_d       = ld_conv ? (b ^ (b >> 1)) : ld_cnt ? (cnt_q ^ (cnt_q >> 1)) : g_q;
        v_d       = (ld_conv || ld_cnt) ? 1'b1 : out_ready ? 1'b0 : v_q;
        cnt_d     = ld_cnt ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= 1'b0;
            g_q   <= 16'h0000;
            cnt_q <= 16'h0000;
        end else begin
            v_q   <= v_d;
            g_q   <= g_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = v_q;
    assign g         = g_q;
    assign cnt       = cnt_q;
endmodule

// File: tb/tb_grey_encoder_16.sv
// tb_grey_encoder_16: table-driven directed checks plus a long counter-wrap sequence
module tb_grey_encoder_16;
    logic        clk = 1'b0;
    logic        rst, mode, in_valid, count_en, out_ready;
    logic [15:0] b;
    logic        in_ready, out_valid;
    logic [15:0] g, cnt;
    int          n_chk = 0;
    int          n_err = 0;

    grey_encoder_16 dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .b(b), .count_en(count_en), .out_valid(out_valid), .out_ready(out_ready),
        .g(g), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, mode, iv;
        logic [15:0] b;
        logic        ce, ordy, e_rdy, e_v;
        logic [15:0] e_g, e_cnt;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input logic r, input logic m, input logic iv,
                       input logic [15:0] bb, input logic ce, input logic ordy,
                       input logic e_rdy, input logic e_v, input logic [15:0] e_g,
                       input logic [15:0] e_cnt);
        vec_t v;
        v.name = name; v.rst = r; v.mode = m; v.iv = iv; v.b = bb; v.ce = ce; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_g = e_g; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic iv, input logic [15:0] bb,
                         input logic ce, input logic ordy);
        rst = r; mode = m; in_valid = iv; b = bb; count_en = ce; out_ready = ordy;
    endtask

    logic [15:0] prev_g;
    logic [15:0] exp_g[4]  = '{16'h8001, 16'h8000, 16'h0000, 16'h0001};
    logic [15:0] exp_c[4]  = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002};

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        // name, rst, mode, iv, b, ce, ordy | in_ready, out_valid, g, cnt (after edge)
        add("reset",     1, 0, 1, 16'h1234, 0, 1, 0, 0, 16'h0000, 16'h0000);
        add("conv0000",  0, 0, 1, 16'h0000, 0, 1, 1, 1, 16'h0000, 16'h0000);
        add("conv0001",  0, 0, 1, 16'h0001, 0, 1, 1, 1, 16'h0001, 16'h0000);
        add("conv00FF",  0, 0, 1, 16'h00FF, 0, 1, 1, 1, 16'h0080, 16'h0000);
        add("convFFFF",  0, 0, 1, 16'hFFFF, 0, 1, 1, 1, 16'h8000, 16'h0000);
        add("conv8000",  0, 0, 1, 16'h8000, 1, 1, 1, 1, 16'hC000, 16'h0000);
        add("conv1234",  0, 0, 1, 16'h1234, 0, 1, 1, 1, 16'h1B2E, 16'h0000);
        add("pop",       0, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h1B2E, 16'h0000);
        add("ld_stall",  0, 0, 1, 16'h1234, 0, 0, 1, 1, 16'h1B2E, 16'h0000);
        add("stall1",    0, 0, 1, 16'h5555, 0, 0, 0, 1, 16'h1B2E, 16'h0000);
        add("stall2",    0, 0, 1, 16'h5555, 0, 0, 0, 1, 16'h1B2E, 16'h0000);
        add("stall3",    0, 0, 1, 16'h5555, 0, 0, 0, 1, 16'h1B2E, 16'h0000);
        add("pop_load",  0, 0, 1, 16'h5555, 0, 1, 1, 1, 16'h7FFF, 16'h0000);
        add("mode_hold", 0, 1, 1, 16'hFFFF, 1, 0, 0, 1, 16'h7FFF, 16'h0000);
        add("mode_cnt",  0, 1, 1, 16'hFFFF, 1, 1, 0, 1, 16'h0000, 16'h0001);
        add("ce_ignored",0, 0, 0, 16'h0000, 1, 1, 1, 0, 16'h0000, 16'h0001);
        add("reset2",    1, 1, 0, 16'h0000, 1, 1, 0, 0, 16'h0000, 16'h0000);
        add("cnt0",      0, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0000, 16'h0001);
        add("cnt1",      0, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0001, 16'h0002);
        add("cnt2",      0, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0003, 16'h0003);
        add("cnt3",      0, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0002, 16'h0004);
        add("cnt4",      0, 1, 0, 16'h0000, 1, 1, 0, 1, 16'h0006, 16'h0005);
        add("cnt_drain", 0, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0006, 16'h0005);
        add("cbp0",      0, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0007, 16'h0006);
        add("cbp1",      0, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0007, 16'h0006);
        add("cbp2",      0, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0007, 16'h0006);
        add("cbp3",      0, 1, 0, 16'h0000, 1, 0, 0, 1, 16'h0007, 16'h0006);
        add("cbp_pop",   0, 1, 0, 16'h0000, 0, 1, 0, 0, 16'h0007, 16'h0006);
        add("rst_hold",  0, 0, 1, 16'h1234, 0, 0, 1, 1, 16'h1B2E, 16'h0006);
        add("rst_mid",   1, 0, 1, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000);
        add("post_rst",  0, 0, 1, 16'h1234, 0, 1, 1, 1, 16'h1B2E, 16'h0000);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].mode, tbl[i].iv, tbl[i].b, tbl[i].ce, tbl[i].ordy);
            #1 chk({tbl[i].name, ".in_ready"}, 32'(in_ready), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk({tbl[i].name, ".out_valid"}, 32'(out_valid), 32'(tbl[i].e_v));
            chk({tbl[i].name, ".g"}, 32'(g), 32'(tbl[i].e_g));
            chk({tbl[i].name, ".cnt"}, 32'(cnt), 32'(tbl[i].e_cnt));
        end

        // Counter wrap: run the counter up to 0xFFFE, then step across the wrap
        drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 65534; i++) @(posedge clk);
        #1 chk("wrap.preload_cnt", 32'(cnt), 32'h0000FFFE);
        prev_g = g;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("wrap.g%0d", i), 32'(g), 32'(exp_g[i]));
            chk($sformatf("wrap.cnt%0d", i), 32'(cnt), 32'(exp_c[i]));
            chk($sformatf("wrap.onebit%0d", i), 32'($countones(g ^ prev_g)), 32'd1);
            prev_g = g;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
